// File: rtl/tron_occupancy_pkg.sv
// tron_occupancy_pkg: shared owner codes, board defaults, tron colours and FSM states
package tron_occupancy_pkg;
  localparam int unsigned H_RES_DEF = 160;
  localparam int unsigned V_RES_DEF = 120;
  localparam int unsigned ADDR_W = 15;
  localparam logic [1:0] OWN_EMPTY = 2'b00;
  localparam logic [1:0] OWN_A = 2'b01;
  localparam logic [1:0] OWN_B = 2'b10;
  localparam logic [2:0] COLOUR_A_DEF = 3'b001;
  localparam logic [2:0] COLOUR_B_DEF = 3'b100;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD, S_CHK} state_t;
endpackage

// File: rtl/tron_occupancy_ram.sv
// tron_occupancy_ram: single-port occupancy store, sync read (1 cycle) and sync write, no reset
// Ports: clk, we (write enable), addr (cell index), wdata (owner code to write), rdata (owner code read)
module tron_occupancy_ram #(
  parameter int unsigned DEPTH = 19200
) (
  input  logic        clk,
  input  logic        we,
  input  logic [14:0] addr,
  input  logic [1:0]  wdata,
  output logic [1:0]  rdata
);
  logic [1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/tron_occupancy_reader.sv
// tron_occupancy_reader: occupancy map that checks tron moves for wall/trail collisions and plots clean moves
// Ports: clk, resetn (async active-low); clear sweep request; req_* move handshake (x, y, id);
//   resp_* collision result pulse; plot/plot_x/plot_y/plot_colour pixel write; busy during sweep;
//   hits_a/hits_b collision counters, live only when TRON_HIT_COUNT_EN is defined (else tied to 0).
module tron_occupancy_reader
  import tron_occupancy_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF,
  parameter logic [2:0] COLOUR_A = COLOUR_A_DEF,
  parameter logic [2:0] COLOUR_B = COLOUR_B_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic       req_id,
  output logic       resp_valid,
  output logic       resp_wall,
  output logic       resp_hit,
  output logic [1:0] resp_owner,
  output logic       plot,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour,
  output logic       busy,
  output logic [7:0] hits_a,
  output logic [7:0] hits_b
);
  localparam logic [14:0] LAST = 15'(H_RES * V_RES - 1);
  state_t state, state_nx;
  logic [14:0] sweep, laddr;
  logic [7:0] lx;
  logic [6:0] ly;
  logic lid, chk, wall, hit, accept;
  logic [1:0] rdata;
  assign chk = state == S_CHK;
  assign wall = 32'(lx) >= H_RES || 32'(ly) >= V_RES;
  assign hit = !wall && rdata != OWN_EMPTY;
  assign accept = state == S_IDLE && !clear && req_valid;
  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: state_nx = sweep == LAST ? S_IDLE : S_CLEAR;
      S_IDLE:  state_nx = clear ? S_CLEAR : req_valid ? S_RD : S_IDLE;
      S_RD:    state_nx = S_CHK;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_CLEAR;
      sweep <= '0;
      laddr <= '0;
      lx <= '0;
      ly <= '0;
      lid <= 1'b0;
    end else begin
      state <= state_nx;
      sweep <= state == S_CLEAR ? sweep + 15'd1 : '0;
      if (accept) begin
        lx <= req_x;
        ly <= req_y;
        lid <= req_id;
        // y*160 as (y<<7)+(y<<5); the wide sum is only written back for in-range cells
        laddr <= {1'b0, req_y, 7'b0} + {3'b0, req_y, 5'b0} + {7'b0, req_x};
      end
    end
  end
  assign req_ready = state == S_IDLE;
  assign busy = state == S_CLEAR && resetn;
  assign resp_valid = chk;
  assign resp_wall = chk && wall;
  assign resp_hit = chk && hit;
  assign resp_owner = chk && !wall ? rdata : OWN_EMPTY;
  assign plot = chk && !wall && !hit;
  assign plot_x = plot ? lx : '0;
  assign plot_y = plot ? ly : '0;
  assign plot_colour = plot ? (lid ? COLOUR_B : COLOUR_A) : '0;
  tron_occupancy_ram #(.DEPTH(H_RES * V_RES)) u_ram (
    .clk  (clk),
    .we   (state == S_CLEAR || plot),
    .addr (state == S_CLEAR ? sweep : laddr),
    .wdata(state == S_CLEAR ? OWN_EMPTY : {lid, !lid}),
    .rdata(rdata)
  );
`ifdef TRON_HIT_COUNT_EN
  logic [7:0] cnt_a, cnt_b;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (state == S_IDLE && clear) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (chk && (wall || hit)) begin
      if (!lid && cnt_a != 8'hff) cnt_a <= cnt_a + 8'd1;
      if (lid && cnt_b != 8'hff) cnt_b <= cnt_b + 8'd1;
    end
  end
  assign hits_a = cnt_a;
  assign hits_b = cnt_b;
`else
  assign hits_a = '0;
  assign hits_b = '0;
`endif
endmodule

// File: tb/tb_tron_occupancy_reader.sv
// tb_tron_occupancy_reader: directed scoreboard bench for tron_occupancy_reader
module tb_tron_occupancy_reader;
  logic clk = 1'b0;
  logic resetn, clear, req_valid, req_id;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic req_ready, resp_valid, resp_wall, resp_hit, plot, busy;
  logic [1:0] resp_owner;
  logic [7:0] plot_x, hits_a, hits_b;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  typedef struct packed {
    logic wall;
    logic hit;
    logic [1:0] owner;
    logic plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } exp_t;
  exp_t sb[$];
  logic [1:0] occ[int];
  int hits_m[2];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  tron_occupancy_reader dut (
    .clk(clk), .resetn(resetn), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_id(req_id), .resp_valid(resp_valid), .resp_wall(resp_wall),
    .resp_hit(resp_hit), .resp_owner(resp_owner), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .busy(busy), .hits_a(hits_a), .hits_b(hits_b)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    occ.delete();
    hits_m[0] = 0;
    hits_m[1] = 0;
  endtask
  task automatic predict(input int x, input int y, input int id);
    exp_t e;
    int a;
    a = y * 160 + x;
    e.wall = x >= 160 || y >= 120;
    e.owner = e.wall ? 2'b00 : (occ.exists(a) ? occ[a] : 2'b00);
    e.hit = !e.wall && e.owner != 2'b00;
    e.plot = !e.wall && !e.hit;
    e.x = e.plot ? 8'(x) : 8'd0;
    e.y = e.plot ? 7'(y) : 7'd0;
    e.colour = e.plot ? (id == 1 ? 3'b100 : 3'b001) : 3'b000;
    if (e.plot) occ[a] = id == 1 ? 2'b10 : 2'b01;
    if ((e.wall || e.hit) && hits_m[id] < 255) hits_m[id]++;
    sb.push_back(e);
  endtask
  task automatic send(input string tag, input int x, input int y, input int id);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_x = 8'(x);
    req_y = 7'(y);
    req_id = id[0];
    req_valid = 1'b1;
    predict(x, y, id);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_rd_quiet"}, 32'(resp_valid), 32'd0);
    n = 1;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd2);
    e = sb.pop_front();
    check({tag, "_wall"}, 32'(resp_wall), 32'(e.wall));
    check({tag, "_hit"}, 32'(resp_hit), 32'(e.hit));
    check({tag, "_owner"}, 32'(resp_owner), 32'(e.owner));
    check({tag, "_plot"}, 32'(plot), 32'(e.plot));
    check({tag, "_plot_x"}, 32'(plot_x), 32'(e.x));
    check({tag, "_plot_y"}, 32'(plot_y), 32'(e.y));
    check({tag, "_colour"}, 32'(plot_colour), 32'(e.colour));
`ifdef TRON_HIT_COUNT_EN
    @(negedge clk);
    check({tag, "_hits_a"}, 32'(hits_a), 32'(hits_m[0]));
    check({tag, "_hits_b"}, 32'(hits_b), 32'(hits_m[1]));
`else
    @(negedge clk);
    check({tag, "_hits_a"}, 32'(hits_a), 32'd0);
    check({tag, "_hits_b"}, 32'(hits_b), 32'd0);
`endif
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask
  task automatic sweep_wait(input string tag);
    int cnt, bad;
    cnt = 0;
    bad = 0;
    while (busy && cnt < 20000) begin
      cnt++;
      if (req_ready) bad++;
      @(negedge clk);
      #1;
    end
    req_valid = 1'b0;
    check({tag, "_cycles"}, 32'(cnt), 32'd19200);
    check({tag, "_ready_low"}, 32'(bad), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    model_clear();
  endtask
  initial begin
    resetn = 1'b0;
    clear = 1'b0;
    req_valid = 1'b0;
    req_x = '0;
    req_y = '0;
    req_id = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp", 32'(resp_valid), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    req_valid = 1'b1;
    resetn = 1'b1;
    #1;
    sweep_wait("init_sweep");
    @(negedge clk);
    send("first", 25, 25, 0);
    send("other_hit", 25, 25, 1);
    send("self_hit", 25, 25, 0);
    send("wall_x", 160, 10, 0);
    send("wall_y", 10, 120, 1);
    send("alias_cell", 0, 11, 1);
    send("corner", 159, 119, 1);
    send("corner_hit", 159, 119, 0);
    send("origin", 0, 0, 0);
    clear = 1'b1;
    req_valid = 1'b1;
    req_x = 8'd0;
    req_y = 7'd0;
    req_id = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    req_valid = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_no_accept", 32'(resp_valid), 32'd0);
    #1;
    sweep_wait("clr_sweep");
    @(negedge clk);
    send("after_clr", 25, 25, 1);
    send("claim_100", 100, 100, 1);
    req_x = 8'd100;
    req_y = 7'd100;
    req_id = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    check("mid_rst_resp", 32'(resp_valid), 32'd0);
    check("mid_rst_plot", 32'(plot), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    sweep_wait("rst_sweep");
    @(negedge clk);
    send("after_rst", 100, 100, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
